data_island_packet_serializer: RTL and testbench

- Consumes one 24-bit packet header plus four 56-bit subpackets, as produced by the info-frame/packet generators.
- Computes the BCH parity for each and serialises the full 32-cycle data-island packet onto the 9 TERC4 payload bits, one slice per pixel clock.
- Sits between the packet generators/packet picker and the TERC4 encoder.
- Guard bands, preambles and hsync/vsync insertion are done downstream.

---
 rtl/hdmi_packet_pkg.sv | 29 ++
 rtl/bch_ecc_accumulator.sv | 40 ++++
 rtl/data_island_packet_serializer.sv | 121 ++++++++++++
 tb/tb_data_island_packet_serializer.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_packet_pkg.sv
// Shared constants, slice type and BCH parity step for the
// data-island packet serializer.
package hdmi_packet_pkg;

    localparam int PACKET_SLICES    = 32;
    localparam int HEADER_DATA_BITS = 24;
    localparam int SUB_DATA_BITS    = 56;
    localparam int SUBPACKET_COUNT  = 4;
    localparam int SUB_DATA_SLICES  = SUB_DATA_BITS / 2;

    localparam logic [7:0] BCH_POLY_DEFAULT = 8'h83;

    typedef logic [8:0] packet_slice_t;

    // Reflected LFSR step: one message bit folded into the parity byte.
    function automatic logic [7:0] bch_step(
        input logic [7:0] ecc,
        input logic       din,
        input logic [7:0] poly = BCH_POLY_DEFAULT
    );
        logic [7:0] nxt;
        nxt = ecc >> 1;
        if (ecc[0] ^ din) begin
            nxt = nxt ^ poly;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bch_ecc_accumulator.sv
// Running BCH parity over a bit stream, consuming one or two
// message bits per clock (bit 0 of i_data first).
module bch_ecc_accumulator
    import hdmi_packet_pkg::*;
#(
    parameter int         BITS_PER_CLK = 1,
    parameter logic [7:0] POLY         = BCH_POLY_DEFAULT
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_clear,
    input  logic                    i_enable,
    input  logic [BITS_PER_CLK-1:0] i_data,
    output logic [7:0]              o_ecc
);

    logic [7:0] r_ecc;
    logic [7:0] w_next;

    always_comb begin
        w_next = r_ecc;
        for (int i = 0; i < BITS_PER_CLK; i++) begin
            w_next = bch_step(w_next, i_data[i], POLY);
        end
    end

    // Clear wins over enable so a back-to-back start restarts cleanly.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_ecc <= '0;
        end else if (i_clear) begin
            r_ecc <= '0;
        end else if (i_enable) begin
            r_ecc <= w_next;
        end
    end

    assign o_ecc = r_ecc;

endmodule

// File: rtl/data_island_packet_serializer.sv
// Serialises a header plus four subpackets, with BCH parity appended,
// into 32 nine-bit TERC4 payload slices.
module data_island_packet_serializer
    import hdmi_packet_pkg::*;
#(
    parameter int         BACK_TO_BACK = 1,
    parameter logic [7:0] BCH_POLY     = BCH_POLY_DEFAULT
) (
    input  logic        clk_pixel,
    input  logic        reset_n,
    input  logic        start,
    input  logic [23:0] header,
    input  logic [55:0] sub [3:0],
    output logic        ready,
    output logic        packet_valid,
    output logic        packet_first,
    output logic [8:0]  packet_data
);

    logic        r_busy;
    logic [4:0]  r_cnt;
    logic [23:0] r_header;
    logic [55:0] r_sub [3:0];

    logic        w_last;
    logic        w_accept;
    logic        w_hdr_phase;
    logic        w_sub_phase;
    logic        w_hdr_bit;
    logic [3:0]  w_even;
    logic [3:0]  w_odd;
    logic [7:0]  w_hecc;
    logic [7:0]  w_secc [3:0];
    packet_slice_t w_slice;

    assign w_last   = r_busy && (r_cnt == 5'd31);
    assign ready    = !r_busy || ((BACK_TO_BACK != 0) && w_last);
    assign w_accept = start && ready;

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_header <= '0;
            for (int k = 0; k < SUBPACKET_COUNT; k++) begin
                r_sub[k] <= '0;
            end
        end else if (w_accept) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_header <= header;
            for (int k = 0; k < SUBPACKET_COUNT; k++) begin
                r_sub[k] <= sub[k];
            end
        end else if (r_busy) begin
            r_cnt <= r_cnt + 5'd1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign w_hdr_phase = r_cnt < 5'(HEADER_DATA_BITS);
    assign w_sub_phase = r_cnt < 5'(SUB_DATA_SLICES);
    assign w_hdr_bit   = w_hdr_phase ? r_header[r_cnt] : 1'b0;

    bch_ecc_accumulator #(
        .BITS_PER_CLK (1),
        .POLY         (BCH_POLY)
    ) u_hecc (
        .i_clk     (clk_pixel),
        .i_reset_n (reset_n),
        .i_clear   (w_accept),
        .i_enable  (r_busy && w_hdr_phase),
        .i_data    (w_hdr_bit),
        .o_ecc     (w_hecc)
    );

    for (genvar k = 0; k < SUBPACKET_COUNT; k++) begin : g_sub
        assign w_even[k] = w_sub_phase ? r_sub[k][{r_cnt, 1'b0}] : 1'b0;
        assign w_odd[k]  = w_sub_phase ? r_sub[k][{r_cnt, 1'b1}] : 1'b0;

        bch_ecc_accumulator #(
            .BITS_PER_CLK (2),
            .POLY         (BCH_POLY)
        ) u_secc (
            .i_clk     (clk_pixel),
            .i_reset_n (reset_n),
            .i_clear   (w_accept),
            .i_enable  (r_busy && w_sub_phase),
            .i_data    ({w_odd[k], w_even[k]}),
            .o_ecc     (w_secc[k])
        );
    end

    // Data phase passes latched bits; parity phase indexes the held ECC.
    always_comb begin
        w_slice = '0;
        if (r_busy) begin
            if (w_hdr_phase) begin
                w_slice[0] = w_hdr_bit;
            end else begin
                w_slice[0] = w_hecc[r_cnt[2:0]];
            end
            for (int k = 0; k < SUBPACKET_COUNT; k++) begin
                if (w_sub_phase) begin
                    w_slice[1+k] = w_even[k];
                    w_slice[5+k] = w_odd[k];
                end else begin
                    w_slice[1+k] = w_secc[k][{r_cnt[1:0], 1'b0}];
                    w_slice[5+k] = w_secc[k][{r_cnt[1:0], 1'b1}];
                end
            end
        end
    end

    assign packet_valid = r_busy;
    assign packet_first = r_busy && (r_cnt == 5'd0);
    assign packet_data  = w_slice;

endmodule

// File: tb/tb_data_island_packet_serializer.sv
// Directed bench for the data-island serializer: one instance with
// back-to-back acceptance, one with a mandatory idle gap.
module tb_data_island_packet_serializer;
    import hdmi_packet_pkg::*;

    logic        clk_pixel = 1'b0;
    logic        reset_n;
    logic        start;
    logic        start0;
    logic [23:0] header;
    logic [55:0] sub [3:0];

    logic        ready,  packet_valid,  packet_first;
    logic [8:0]  packet_data;
    logic        ready0, packet_valid0, packet_first0;
    logic [8:0]  packet_data0;

    int checks   = 0;
    int failures = 0;

    always #5 clk_pixel = ~clk_pixel;

    data_island_packet_serializer #(.BACK_TO_BACK(1)) dut (
        .clk_pixel    (clk_pixel),
        .reset_n      (reset_n),
        .start        (start),
        .header       (header),
        .sub          (sub),
        .ready        (ready),
        .packet_valid (packet_valid),
        .packet_first (packet_first),
        .packet_data  (packet_data)
    );

    data_island_packet_serializer #(.BACK_TO_BACK(0)) dut0 (
        .clk_pixel    (clk_pixel),
        .reset_n      (reset_n),
        .start        (start0),
        .header       (header),
        .sub          (sub),
        .ready        (ready0),
        .packet_valid (packet_valid0),
        .packet_first (packet_first0),
        .packet_data  (packet_data0)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bit-serial reference parity, LSB of the message first.
    function automatic logic [7:0] ref_ecc(input logic [63:0] bits, input int len);
        logic [7:0] e;
        logic       fb;
        e = 8'h00;
        for (int i = 0; i < len; i++) begin
            fb = e[0] ^ bits[i];
            e  = e >> 1;
            if (fb) e = e ^ 8'h83;
        end
        return e;
    endfunction

    function automatic packet_slice_t ref_slice(
        input logic [23:0] h, input logic [55:0] s [3:0], input int n);
        packet_slice_t d;
        logic [7:0]    e;
        d = '0;
        if (n < 24) begin
            d[0] = h[n];
        end else begin
            e    = ref_ecc({40'b0, h}, 24);
            d[0] = e[n-24];
        end
        for (int k = 0; k < 4; k++) begin
            if (n < 28) begin
                d[1+k] = s[k][2*n];
                d[5+k] = s[k][2*n+1];
            end else begin
                e      = ref_ecc({8'b0, s[k]}, 56);
                d[1+k] = e[2*(n-28)];
                d[5+k] = e[2*(n-28)+1];
            end
        end
        return d;
    endfunction

    function automatic logic [55:0] rand56();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[55:0];
    endfunction

    // Parity bytes as seen on the wire: {sub3,sub2,sub1,sub0,header}.
    function automatic logic [39:0] wire_ecc(input packet_slice_t cap [32]);
        logic [39:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i] = cap[24+i][0];
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                r[8+8*k+2*j]   = cap[28+j][1+k];
                r[8+8*k+2*j+1] = cap[28+j][5+k];
            end
        end
        return r;
    endfunction

    function automatic logic [39:0] model_ecc(input logic [23:0] h, input logic [55:0] s [3:0]);
        logic [39:0] r;
        r[7:0] = ref_ecc({40'b0, h}, 24);
        for (int k = 0; k < 4; k++) r[8+8*k +: 8] = ref_ecc({8'b0, s[k]}, 56);
        return r;
    endfunction

    // Sends one packet on the back-to-back instance and records 32 slices.
    task automatic run_packet(
        input  logic [23:0]   h,
        input  logic [55:0]   s [3:0],
        output packet_slice_t cap [32],
        output logic [31:0]   vld,
        output logic [31:0]   fst,
        output logic [31:0]   rdy
    );
        int w;
        w = 0;
        @(negedge clk_pixel);
        while (!ready && w < 100) begin
            @(negedge clk_pixel);
            w++;
        end
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: ready=%b required 1", ready);
        end
        header = h;
        sub    = s;
        start  = 1'b1;
        @(negedge clk_pixel);
        start  = 1'b0;
        header = $urandom();
        for (int k = 0; k < 4; k++) sub[k] = rand56();
        for (int i = 0; i < 32; i++) begin
            cap[i] = packet_data;
            vld[i] = packet_valid;
            fst[i] = packet_first;
            rdy[i] = ready;
            if (i < 31) @(negedge clk_pixel);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        start0  = 1'b0;
        header  = '0;
        for (int k = 0; k < 4; k++) sub[k] = '0;
        repeat (3) @(negedge clk_pixel);
        checks++;
        if ({ready, packet_valid, packet_first, packet_data} !== 12'b1000_0000_0000) begin
            failures++;
            $display("FAIL reset_outputs: rdy=%b v=%b f=%b d=%h required 1 0 0 000",
                     ready, packet_valid, packet_first, packet_data);
        end
        checks++;
        if ({ready0, packet_valid0, packet_first0, packet_data0} !== 12'b1000_0000_0000) begin
            failures++;
            $display("FAIL reset_outputs_nob2b: rdy=%b v=%b f=%b d=%h required 1 0 0 000",
                     ready0, packet_valid0, packet_first0, packet_data0);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_zero_packet();
        packet_slice_t cap [32];
        logic [31:0] vld, fst, rdy;
        logic [55:0] s [3:0];
        logic [8:0]  acc;
        for (int k = 0; k < 4; k++) s[k] = '0;
        run_packet(24'h0, s, cap, vld, fst, rdy);
        acc = '0;
        for (int i = 0; i < 32; i++) acc = acc | cap[i];
        checks++;
        if (vld !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL zero_valid: got %h required ffffffff", vld);
        end
        checks++;
        if (fst !== 32'h0000_0001) begin
            failures++;
            $display("FAIL zero_first: got %h required 00000001", fst);
        end
        checks++;
        if (acc !== 9'h000) begin
            failures++;
            $display("FAIL zero_data: or of slices %h required 000", acc);
        end
        checks++;
        if (rdy !== 32'h8000_0000) begin
            failures++;
            $display("FAIL zero_ready_busy: got %h required 80000000", rdy);
        end
        @(negedge clk_pixel);
        checks++;
        if ({ready, packet_valid, packet_first, packet_data} !== 12'b1000_0000_0000) begin
            failures++;
            $display("FAIL zero_after: rdy=%b v=%b f=%b d=%h required 1 0 0 000",
                     ready, packet_valid, packet_first, packet_data);
        end
    endtask

    task automatic test_header_parity();
        packet_slice_t cap [32];
        logic [31:0] vld, fst, rdy;
        logic [55:0] s [3:0];
        logic [7:0]  e;
        logic [8:1]  other;
        for (int k = 0; k < 4; k++) s[k] = '0;
        run_packet(24'h800000, s, cap, vld, fst, rdy);
        for (int i = 0; i < 8; i++) e[i] = cap[24+i][0];
        other = '0;
        for (int i = 0; i < 32; i++) other = other | cap[i][8:1];
        checks++;
        if (cap[23][0] !== 1'b1) begin
            failures++;
            $display("FAIL hdr_bit23: got %b required 1", cap[23][0]);
        end
        checks++;
        if (e !== 8'h83) begin
            failures++;
            $display("FAIL hdr_ecc: got %h required 83", e);
        end
        checks++;
        if (other !== 8'h00) begin
            failures++;
            $display("FAIL hdr_other_lanes: got %h required 00", other);
        end
    endtask

    task automatic test_sub_parity();
        packet_slice_t cap [32];
        logic [31:0] vld, fst, rdy;
        logic [55:0] s [3:0];
        logic [7:0]  pairs;
        logic [8:0]  other;
        for (int k = 0; k < 4; k++) s[k] = '0;
        s[2] = 56'h80_0000_0000_0000;
        run_packet(24'h0, s, cap, vld, fst, rdy);
        for (int j = 0; j < 4; j++) pairs[2*j +: 2] = {cap[28+j][7], cap[28+j][3]};
        other = '0;
        for (int i = 0; i < 32; i++) begin
            if (i != 27) other = other | (cap[i] & 9'b1_0111_0111);
            else other = other | (cap[i] & 9'b0_0111_0111);
        end
        checks++;
        if (cap[27][7] !== 1'b1) begin
            failures++;
            $display("FAIL sub2_bit55: got %b required 1", cap[27][7]);
        end
        // {odd,even} per slice: n28=11 n29=00 n30=00 n31=10
        checks++;
        if (pairs !== 8'b10_00_00_11) begin
            failures++;
            $display("FAIL sub2_ecc: got %b required 10000011", pairs);
        end
        checks++;
        if (other !== 9'h000) begin
            failures++;
            $display("FAIL sub2_other_lanes: got %h required 000", other);
        end
    endtask

    task automatic test_audio_infoframe();
        packet_slice_t cap [32];
        logic [31:0] vld, fst, rdy;
        logic [55:0] s [3:0];
        packet_slice_t exp;
        s[0] = 56'h00000000000170;
        s[1] = '0;
        s[2] = '0;
        s[3] = '0;
        run_packet(24'h0A0184, s, cap, vld, fst, rdy);
        for (int i = 0; i < 32; i++) begin
            exp = ref_slice(24'h0A0184, s, i);
            checks++;
            if (cap[i] !== exp) begin
                failures++;
                $display("FAIL audio_slice%0d: got %h required %h", i, cap[i], exp);
            end
        end
    endtask

    task automatic test_linearity();
        packet_slice_t cap [32];
        logic [31:0] vld, fst, rdy;
        logic [23:0] ha, hb;
        logic [55:0] sa [3:0];
        logic [55:0] sb [3:0];
        logic [55:0] sx [3:0];
        logic [39:0] ea, eb, ex, em;
        for (int p = 0; p < 100; p++) begin
            ha = $urandom();
            hb = $urandom();
            for (int k = 0; k < 4; k++) begin
                sa[k] = rand56();
                sb[k] = rand56();
                sx[k] = sa[k] ^ sb[k];
            end
            run_packet(ha, sa, cap, vld, fst, rdy);
            ea = wire_ecc(cap);
            run_packet(hb, sb, cap, vld, fst, rdy);
            eb = wire_ecc(cap);
            run_packet(ha ^ hb, sx, cap, vld, fst, rdy);
            ex = wire_ecc(cap);
            em = model_ecc(ha, sa);
            checks++;
            if (ea !== em) begin
                failures++;
                $display("FAIL lin_model_%0d: got %h required %h", p, ea, em);
            end
            checks++;
            if (ex !== (ea ^ eb)) begin
                failures++;
                $display("FAIL lin_xor_%0d: got %h required %h", p, ex, ea ^ eb);
            end
        end
    endtask

    task automatic test_back_to_back();
        packet_slice_t cap [64];
        logic [63:0] vld, fst;
        logic [23:0] ha, hb;
        logic [55:0] sa [3:0];
        logic [55:0] sb [3:0];
        int bad;
        int w;
        ha = 24'h123456;
        hb = 24'hFEDCBA;
        for (int k = 0; k < 4; k++) begin
            sa[k] = rand56();
            sb[k] = rand56();
        end
        w = 0;
        @(negedge clk_pixel);
        while (!ready && w < 100) begin
            @(negedge clk_pixel);
            w++;
        end
        header = ha;
        sub    = sa;
        start  = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_pixel);
            cap[i] = packet_data;
            vld[i] = packet_valid;
            fst[i] = packet_first;
            if (i == 0) begin
                header = hb;
                sub    = sb;
            end
            if (i == 32) start = 1'b0;
        end
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (cap[i] !== ref_slice(ha, sa, i)) bad++;
            if (cap[32+i] !== ref_slice(hb, sb, i)) bad++;
        end
        checks++;
        if (vld !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++;
            $display("FAIL b2b_valid: got %h required ffffffffffffffff", vld);
        end
        checks++;
        if (fst !== 64'h0000_0001_0000_0001) begin
            failures++;
            $display("FAIL b2b_first: got %h required 0000000100000001", fst);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL b2b_data: %0d slices differ, required 0", bad);
        end
        @(negedge clk_pixel);
        checks++;
        if (packet_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: valid=%b required 0", packet_valid);
        end
    endtask

    task automatic test_gap_mode();
        packet_slice_t cap [66];
        logic [65:0] vld, fst, rdy, exp_v;
        logic [23:0] ha, hb;
        logic [55:0] sa [3:0];
        logic [55:0] sb [3:0];
        int bad;
        ha = 24'h0F0F0F;
        hb = 24'hA5A5A5;
        for (int k = 0; k < 4; k++) begin
            sa[k] = rand56();
            sb[k] = rand56();
        end
        @(negedge clk_pixel);
        header = ha;
        sub    = sa;
        start0 = 1'b1;
        for (int i = 0; i < 66; i++) begin
            @(negedge clk_pixel);
            cap[i] = packet_data0;
            vld[i] = packet_valid0;
            fst[i] = packet_first0;
            rdy[i] = ready0;
            if (i == 0) begin
                header = hb;
                sub    = sb;
            end
            if (i == 33) start0 = 1'b0;
        end
        exp_v = '1;
        exp_v[32] = 1'b0;
        exp_v[65] = 1'b0;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (cap[i] !== ref_slice(ha, sa, i)) bad++;
            if (cap[33+i] !== ref_slice(hb, sb, i)) bad++;
        end
        checks++;
        if (vld !== exp_v) begin
            failures++;
            $display("FAIL gap_valid: got %h required %h", vld, exp_v);
        end
        checks++;
        if (fst !== ((66'b1 << 33) | 66'b1)) begin
            failures++;
            $display("FAIL gap_first: got %h required %h", fst, (66'b1 << 33) | 66'b1);
        end
        checks++;
        if ({rdy[31], rdy[32], rdy[33]} !== 3'b010) begin
            failures++;
            $display("FAIL gap_ready: n31/idle/n0 got %b required 010",
                     {rdy[31], rdy[32], rdy[33]});
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL gap_data: %0d slices differ, required 0", bad);
        end
    endtask

    task automatic test_reset_midpacket();
        packet_slice_t cap [32];
        logic [31:0] vld, fst, rdy;
        logic [23:0] h;
        logic [55:0] s [3:0];
        int bad;
        h = $urandom();
        for (int k = 0; k < 4; k++) s[k] = rand56();
        @(negedge clk_pixel);
        header = h;
        sub    = s;
        start  = 1'b1;
        @(negedge clk_pixel);
        start  = 1'b0;
        repeat (10) @(negedge clk_pixel);
        checks++;
        if (packet_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy: valid=%b required 1", packet_valid);
        end
        reset_n = 1'b0;
        @(negedge clk_pixel);
        checks++;
        if ({ready, packet_valid, packet_first, packet_data} !== 12'b1000_0000_0000) begin
            failures++;
            $display("FAIL mid_reset: rdy=%b v=%b f=%b d=%h required 1 0 0 000",
                     ready, packet_valid, packet_first, packet_data);
        end
        reset_n = 1'b1;
        h = $urandom();
        for (int k = 0; k < 4; k++) s[k] = rand56();
        run_packet(h, s, cap, vld, fst, rdy);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (cap[i] !== ref_slice(h, s, i)) bad++;
        end
        checks++;
        if (bad != 0 || vld !== 32'hFFFF_FFFF || fst !== 32'h1) begin
            failures++;
            $display("FAIL post_reset_packet: bad=%0d v=%h f=%h required 0 ffffffff 00000001",
                     bad, vld, fst);
        end
    endtask

    initial begin
        test_reset();
        test_zero_packet();
        test_header_parity();
        test_sub_parity();
        test_audio_infoframe();
        test_linearity();
        test_back_to_back();
        test_gap_mode();
        test_reset_midpacket();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
